// File: rtl/rvc_asap_5pl_cr_io.sv
// Control-register I/O block beside the MEM-stage data memory: 7-segment digits, LEDs,
// cursor scratch registers, debounced buttons with W1C events and IRQ, switches, cycle counter.

module rvc_asap_5pl_cr_io_btn #(
   parameter int DEBOUNCE_CYC = 16
) (
   input  logic Clock,
   input  logic Rst,
   input  logic raw,
   output logic lvl,
   output logic rise
);
   localparam int CW = $clog2(DEBOUNCE_CYC);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          flip;

   // rise is combinational so the event bit sets on the same edge the level flips
   assign flip = (sync[1] != lvl) && (cnt == CW'(DEBOUNCE_CYC - 1));
   assign rise = flip && !lvl;

   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         sync <= '0;
         cnt  <= '0;
         lvl  <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         if (sync[1] == lvl || flip) cnt <= '0;
         else                        cnt <= cnt + 1'b1;
         if (flip) lvl <= ~lvl;
      end
   end
endmodule

module rvc_asap_5pl_cr_io #(
   parameter int          NUM_SEG7     = 6,
   parameter int          LED_W        = 10,
   parameter int          SW_W         = 10,
   parameter int          NUM_BTN      = 2,
   parameter int          DEBOUNCE_CYC = 16,
   parameter logic [31:0] CR_BASE      = 32'h0000_7000
) (
   input  logic                  Clock,
   input  logic                  Rst,
   input  logic [31:0]           AluOut,
   input  logic [31:0]           RegRdData2,
   input  logic                  CtrlCRMemWrEn,
   input  logic [3:0]            CtrlCRMemByteEn,
   input  logic                  SelCRMemWb,
   output logic [31:0]           CRMemRdDataQ104H,
   input  logic [NUM_BTN-1:0]    Button,
   input  logic [SW_W-1:0]       Switch,
   output logic [8*NUM_SEG7-1:0] SEG7,
   output logic [LED_W-1:0]      LED,
   output logic                  Irq
);
   localparam logic [9:0] W_LED  = 10'h08;
   localparam logic [9:0] W_CURH = 10'h09;
   localparam logic [9:0] W_CURV = 10'h0A;
   localparam logic [9:0] W_LVL  = 10'h10;
   localparam logic [9:0] W_EVT  = 10'h11;
   localparam logic [9:0] W_IE   = 10'h12;
   localparam logic [9:0] W_SW   = 10'h13;
   localparam logic [9:0] W_CYC  = 10'h14;

   logic                    hit, wr;
   logic [9:0]              word;
   logic                    unused_ok;
   logic [NUM_SEG7-1:0][7:0] seg_q, seg_n;
   logic [LED_W-1:0]        led_q, led_n;
   logic [31:0]             curh_q, curh_n, curv_q, curv_n;
   logic [NUM_BTN-1:0]      ie_q, ie_n, evt_q, evt_n, evt_clr, lvl, rise;
   logic [1:0][SW_W-1:0]    sw_sync;
   logic [31:0]             cyc_q, rd_val, rd_q;
   logic                    irq_q;

   function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   assign hit       = AluOut[31:12] == CR_BASE[31:12];
   assign word      = AluOut[11:2];
   assign wr        = CtrlCRMemWrEn && hit;
   assign unused_ok = ^AluOut[1:0];

   rvc_asap_5pl_cr_io_btn #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn [NUM_BTN-1:0] (
      .Clock (Clock),
      .Rst   (Rst),
      .raw   (Button),
      .lvl   (lvl),
      .rise  (rise)
   );

   always_comb begin
      seg_n   = seg_q;
      led_n   = led_q;
      curh_n  = curh_q;
      curv_n  = curv_q;
      ie_n    = ie_q;
      evt_clr = '0;
      if (wr) begin
         for (int i = 0; i < NUM_SEG7; i++)
            if (word == 10'(i) && CtrlCRMemByteEn[0]) seg_n[i] = RegRdData2[7:0];
         case (word)
            W_LED:   led_n  = LED_W'(bmerge(32'(led_q), RegRdData2, CtrlCRMemByteEn));
            W_CURH:  curh_n = bmerge(curh_q, RegRdData2, CtrlCRMemByteEn);
            W_CURV:  curv_n = bmerge(curv_q, RegRdData2, CtrlCRMemByteEn);
            W_IE:    if (CtrlCRMemByteEn[0]) ie_n = RegRdData2[NUM_BTN-1:0];
            W_EVT:   if (CtrlCRMemByteEn[0]) evt_clr = RegRdData2[NUM_BTN-1:0];
            default: ;
         endcase
      end
      // a debounced rising edge beats a same-cycle clear
      evt_n = (evt_q & ~evt_clr) | rise;
   end

   // loads see post-write values so a same-cycle store is bypassed
   always_comb begin
      rd_val = '0;
      if (hit) begin
         for (int i = 0; i < NUM_SEG7; i++)
            if (word == 10'(i)) rd_val = 32'(seg_n[i]);
         case (word)
            W_LED:   rd_val = 32'(led_n);
            W_CURH:  rd_val = curh_n;
            W_CURV:  rd_val = curv_n;
            W_LVL:   rd_val = 32'(lvl);
            W_EVT:   rd_val = 32'(evt_n);
            W_IE:    rd_val = 32'(ie_n);
            W_SW:    rd_val = 32'(sw_sync[1]);
            W_CYC:   rd_val = cyc_q;
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         seg_q   <= '0;
         led_q   <= '0;
         curh_q  <= '0;
         curv_q  <= '0;
         ie_q    <= '0;
         evt_q   <= '0;
         irq_q   <= 1'b0;
         sw_sync <= '0;
         cyc_q   <= '0;
         rd_q    <= '0;
      end else begin
         seg_q   <= seg_n;
         led_q   <= led_n;
         curh_q  <= curh_n;
         curv_q  <= curv_n;
         ie_q    <= ie_n;
         evt_q   <= evt_n;
         irq_q   <= |(evt_q & ie_q);
         sw_sync <= {sw_sync[0], Switch};
         cyc_q   <= cyc_q + 32'd1;
         if (SelCRMemWb) rd_q <= rd_val;
      end
   end

   assign SEG7             = seg_q;
   assign LED              = led_q;
   assign Irq              = irq_q;
   assign CRMemRdDataQ104H = rd_q;
endmodule

// File: tb/tb_rvc_asap_5pl_cr_io.sv
// Bench for rvc_asap_5pl_cr_io: vector table, hand-written button/switch/counter
// sequences, then random bus traffic against a register-map model.
module tb_rvc_asap_5pl_cr_io;
   localparam int D = 16;

   logic        Clock, Rst;
   logic [31:0] AluOut, RegRdData2;
   logic        CtrlCRMemWrEn, SelCRMemWb;
   logic [3:0]  CtrlCRMemByteEn;
   logic [31:0] CRMemRdDataQ104H;
   logic [1:0]  Button;
   logic [9:0]  Switch;
   logic [47:0] SEG7;
   logic [9:0]  LED;
   logic        Irq;

   int checks = 0;
   int errors = 0;

   rvc_asap_5pl_cr_io #(.NUM_SEG7(6), .LED_W(10), .SW_W(10), .NUM_BTN(2),
                        .DEBOUNCE_CYC(D), .CR_BASE(32'h0000_7000)) dut (
      .Clock(Clock), .Rst(Rst), .AluOut(AluOut), .RegRdData2(RegRdData2),
      .CtrlCRMemWrEn(CtrlCRMemWrEn), .CtrlCRMemByteEn(CtrlCRMemByteEn),
      .SelCRMemWb(SelCRMemWb), .CRMemRdDataQ104H(CRMemRdDataQ104H),
      .Button(Button), .Switch(Switch), .SEG7(SEG7), .LED(LED), .Irq(Irq));

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        rd;
      logic [31:0] exp_rd;
      logic [9:0]  exp_led;
      logic [47:0] exp_seg;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic we, input logic [3:0] be, input logic [31:0] addr,
                               input logic [31:0] wd, input logic rd, input logic [31:0] er,
                               input logic [9:0] el, input logic [47:0] es);
      vec_t v;
      v.we = we; v.be = be; v.addr = addr; v.wd = wd; v.rd = rd;
      v.exp_rd = er; v.exp_led = el; v.exp_seg = es;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic step(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd, input logic rd);
      @(negedge Clock);
      CtrlCRMemWrEn = we; CtrlCRMemByteEn = be; AluOut = addr; RegRdData2 = wd; SelCRMemWb = rd;
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      @(negedge Clock);
      Rst = 1'b0;
      CtrlCRMemWrEn = 1'b0; CtrlCRMemByteEn = 4'h0; AluOut = '0; RegRdData2 = '0; SelCRMemWb = 1'b0;
      #1;
      chk("rst_rd", 64'(CRMemRdDataQ104H), 64'h0);
      chk("rst_seg", 64'(SEG7), 64'h0);
      chk("rst_led", 64'(LED), 64'h0);
      chk("rst_irq", 64'(Irq), 64'h0);
      @(negedge Clock);
      @(negedge Clock);
      Rst = 1'b1;
   endtask

   // register-map model for the random phase
   logic [7:0]  m_seg[6];
   logic [9:0]  m_led;
   logic [31:0] m_ch, m_cv, m_cyc, m_rd;
   logic [1:0]  m_ie;
   logic [9:0]  sw_hist[$];
   logic [31:0] addr_tab[18] = '{32'h7000, 32'h7004, 32'h7008, 32'h700C, 32'h7010, 32'h7014,
                                 32'h7018, 32'h701C, 32'h7020, 32'h7024, 32'h7028, 32'h7040,
                                 32'h7044, 32'h7048, 32'h704C, 32'h7050, 32'h8020, 32'h7030};

   function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
      for (int b = 0; b < 4; b++) if (be[b]) o[8*b +: 8] = n[8*b +: 8];
      return o;
   endfunction

   function automatic logic [31:0] m_sw();
      int sz = sw_hist.size();
      return (sz >= 3) ? 32'(sw_hist[sz-3]) : 32'h0;
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      int off = int'({a[11:2], 2'b00});
      if (a[31:12] != 20'h7) return 32'h0;
      if (off < 24) return 32'(m_seg[off/4]);
      case (off)
         32'h20:  return 32'(m_led);
         32'h24:  return m_ch;
         32'h28:  return m_cv;
         32'h48:  return 32'(m_ie);
         32'h4C:  return m_sw();
         32'h50:  return m_cyc;
         default: return 32'h0;
      endcase
   endfunction

   logic [31:0] c1;

   initial begin
      Rst = 1'b1; Button = '0; Switch = '0;
      CtrlCRMemWrEn = 1'b0; CtrlCRMemByteEn = '0; AluOut = '0; RegRdData2 = '0; SelCRMemWb = 1'b0;
      #2;
      do_reset();

      // ---- table-driven bus vectors ----
      foreach (addr_tab[i]) if (i < 6 || (i >= 8 && i <= 14))
         tv.push_back(mk(0, 4'h0, addr_tab[i], 0, 1, 32'h0, 10'h0, 48'h0));
      tv.push_back(mk(0, 4'h0, 32'h7018, 0, 1, 32'h0, 10'h0, 48'h0));
      tv.push_back(mk(1, 4'h1, 32'h7020, 32'hA5A5_00FF, 1, 32'h0FF, 10'h0FF, 48'h0));
      tv.push_back(mk(1, 4'h2, 32'h7020, 32'h0000_0301, 1, 32'h3FF, 10'h3FF, 48'h0));
      tv.push_back(mk(1, 4'hF, 32'h0000_644C, 32'hFFFF_FFFF, 1, 32'h0, 10'h3FF, 48'h0));
      tv.push_back(mk(0, 4'h0, 32'h7023, 0, 1, 32'h3FF, 10'h3FF, 48'h0));
      tv.push_back(mk(1, 4'h1, 32'h7008, 32'h0000_003F, 1, 32'h3F, 10'h3FF, 48'h0000_003F_0000));
      tv.push_back(mk(1, 4'hE, 32'h7008, 32'hFFFF_FF11, 1, 32'h3F, 10'h3FF, 48'h0000_003F_0000));
      tv.push_back(mk(0, 4'h0, 32'h7000, 0, 0, 32'h3F, 10'h3FF, 48'h0000_003F_0000));
      tv.push_back(mk(1, 4'hF, 32'h7024, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 10'h3FF, 48'h0000_003F_0000));
      tv.push_back(mk(1, 4'h5, 32'h7028, 32'h1234_5678, 1, 32'h0034_0078, 10'h3FF, 48'h0000_003F_0000));
      tv.push_back(mk(1, 4'hF, 32'h7040, 32'hFFFF_FFFF, 1, 32'h0, 10'h3FF, 48'h0000_003F_0000));
      tv.push_back(mk(1, 4'hF, 32'h704C, 32'hFFFF_FFFF, 1, 32'h0, 10'h3FF, 48'h0000_003F_0000));
      tv.push_back(mk(1, 4'hF, 32'h7018, 32'hFFFF_FFFF, 1, 32'h0, 10'h3FF, 48'h0000_003F_0000));
      tv.push_back(mk(1, 4'h1, 32'h7014, 32'h0000_00AB, 0, 32'h0, 10'h3FF, 48'hAB00_003F_0000));
      tv.push_back(mk(1, 4'hF, 32'h7048, 32'hFFFF_FFFF, 1, 32'h3, 10'h3FF, 48'hAB00_003F_0000));
      tv.push_back(mk(1, 4'hF, 32'h7044, 32'hFFFF_FFFF, 1, 32'h0, 10'h3FF, 48'hAB00_003F_0000));
      foreach (tv[i]) begin
         step(tv[i].we, tv[i].be, tv[i].addr, tv[i].wd, tv[i].rd);
         chk($sformatf("vec%0d_rd", i), 64'(CRMemRdDataQ104H), 64'(tv[i].exp_rd));
         chk($sformatf("vec%0d_led", i), 64'(LED), 64'(tv[i].exp_led));
         chk($sformatf("vec%0d_seg", i), 64'(SEG7), 64'(tv[i].exp_seg));
      end

      // ---- switch synchroniser latency ----
      Switch = 10'h2A5;
      step(0, 4'h0, 32'h704C, 0, 1); chk("sw_n",  64'(CRMemRdDataQ104H), 64'h0);
      step(0, 4'h0, 32'h704C, 0, 1); chk("sw_n1", 64'(CRMemRdDataQ104H), 64'h0);
      step(0, 4'h0, 32'h704C, 0, 1); chk("sw_n2", 64'(CRMemRdDataQ104H), 64'h2A5);

      // ---- cycle counter difference ----
      step(0, 4'h0, 32'h7050, 0, 1);
      c1 = CRMemRdDataQ104H;
      for (int i = 0; i < 6; i++) step(0, 4'h0, 0, 0, 0);
      step(0, 4'h0, 32'h7050, 0, 1);
      chk("cyc_diff7", 64'(CRMemRdDataQ104H), 64'(c1 + 32'd7));

      // ---- button glitch of D-1 cycles ----
      Button[0] = 1'b1;
      for (int i = 0; i < D - 1; i++) step(0, 4'h0, 0, 0, 0);
      Button[0] = 1'b0;
      for (int i = 0; i < D + 4; i++) step(0, 4'h0, 32'h7044, 0, 1);
      chk("glitch_evt", 64'(CRMemRdDataQ104H), 64'h0);
      step(0, 4'h0, 32'h7040, 0, 1);
      chk("glitch_lvl", 64'(CRMemRdDataQ104H), 64'h0);
      chk("glitch_irq", 64'(Irq), 64'h0);

      // ---- held press: event at pin+D+1, Irq one edge later ----
      Button[0] = 1'b1;
      for (int k = 0; k <= D + 3; k++) begin
         step(0, 4'h0, 32'h7044, 0, 1);
         chk($sformatf("press_evt_k%0d", k), 64'(CRMemRdDataQ104H), (k >= D + 1) ? 64'h1 : 64'h0);
         chk($sformatf("press_irq_k%0d", k), 64'(Irq), (k >= D + 2) ? 64'h1 : 64'h0);
      end

      // ---- W1C clear ----
      step(1, 4'h1, 32'h7044, 32'h1, 1);
      chk("w1c_rd", 64'(CRMemRdDataQ104H), 64'h0);
      chk("w1c_irq_hold", 64'(Irq), 64'h1);
      step(0, 4'h0, 32'h7040, 0, 1);
      chk("w1c_irq_drop", 64'(Irq), 64'h0);
      chk("lvl_high", 64'(CRMemRdDataQ104H), 64'h1);

      // ---- release: no event on falling edge ----
      Button[0] = 1'b0;
      for (int i = 0; i < D + 4; i++) step(0, 4'h0, 32'h7044, 0, 1);
      chk("fall_evt", 64'(CRMemRdDataQ104H), 64'h0);

      // ---- clear coincident with a new rising edge ----
      Button[0] = 1'b1;
      for (int k = 0; k <= D + 1; k++) begin
         if (k == D + 1) step(1, 4'h1, 32'h7044, 32'h1, 1);
         else            step(0, 4'h0, 32'h7044, 0, 1);
      end
      chk("setwins_rd", 64'(CRMemRdDataQ104H), 64'h1);
      step(0, 4'h0, 32'h7044, 0, 1);
      chk("setwins_hold", 64'(CRMemRdDataQ104H), 64'h1);

      // ---- reset mid-debounce (counter at D-2) ----
      Button[0] = 1'b0;
      for (int i = 0; i < D + 4; i++) step(0, 4'h0, 0, 0, 0);
      Button[0] = 1'b1;
      for (int i = 0; i < D; i++) step(0, 4'h0, 0, 0, 0);
      do_reset();
      step(0, 4'h0, 32'h7020, 0, 1);
      chk("post_rst_led_rd", 64'(CRMemRdDataQ104H), 64'h0);
      for (int k = 1; k <= D + 1; k++) begin
         step(0, 4'h0, 32'h7044, 0, 1);
         chk($sformatf("rst_dbnc_evt_k%0d", k), 64'(CRMemRdDataQ104H), (k >= D) ? 64'h1 : 64'h0);
         chk($sformatf("rst_dbnc_irq_k%0d", k), 64'(Irq), 64'h0);
      end

      // ---- random bus traffic vs model ----
      Button = '0; Switch = '0;
      do_reset();
      foreach (m_seg[i]) m_seg[i] = '0;
      m_led = '0; m_ch = '0; m_cv = '0; m_ie = '0; m_rd = '0;
      m_cyc = 32'd1;
      sw_hist.delete();
      sw_hist.push_back(10'h0);
      for (int n = 0; n < 300; n++) begin
         logic [31:0] a, d, w32;
         logic        w, r;
         logic [3:0]  be;
         logic [9:0]  sw;
         logic [47:0] es;
         int          off;
         a  = addr_tab[$urandom_range(0, 17)] | 32'($urandom_range(0, 3));
         d  = $urandom;
         be = 4'($urandom_range(0, 15));
         w  = 1'($urandom_range(0, 1));
         r  = 1'($urandom_range(0, 1));
         sw = 10'($urandom);
         @(negedge Clock);
         CtrlCRMemWrEn = w; CtrlCRMemByteEn = be; AluOut = a; RegRdData2 = d; SelCRMemWb = r;
         Switch = sw;
         sw_hist.push_back(sw);
         off = int'({a[11:2], 2'b00});
         if (w && a[31:12] == 20'h7) begin
            if (off < 24) begin
               if (be[0]) m_seg[off/4] = d[7:0];
            end else if (off == 32'h20) begin
               w32 = bmerge(32'(m_led), d, be);
               m_led = w32[9:0];
            end else if (off == 32'h24) m_ch = bmerge(m_ch, d, be);
            else if (off == 32'h28) m_cv = bmerge(m_cv, d, be);
            else if (off == 32'h48 && be[0]) m_ie = d[1:0];
         end
         if (r) m_rd = m_read(a);
         @(posedge Clock);
         #1;
         m_cyc = m_cyc + 32'd1;
         es = '0;
         for (int i = 0; i < 6; i++) es[8*i +: 8] = m_seg[i];
         chk($sformatf("rnd%0d_rd a=%h", n, a), 64'(CRMemRdDataQ104H), 64'(m_rd));
         chk($sformatf("rnd%0d_led", n), 64'(LED), 64'(m_led));
         chk($sformatf("rnd%0d_seg", n), 64'(SEG7), 64'(es));
         chk($sformatf("rnd%0d_irq", n), 64'(Irq), 64'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rvc_asap_5pl_cr_io.md
# rvc_asap_5pl_cr_io

Parametrised control-register I/O block for the 5-stage rvc_asap core, sitting on the MEM stage beside the data memory and serving LOAD/STORE accesses that decode into the CR window. It generalises the CR memory to a configurable number of 7-segment digits, LED and switch widths, and button inputs. It also adds synchronisers, per-button debounce, sticky write-1-to-clear button events with an interrupt line, byte-enable writes and a free-running cycle counter.

## Interface
- NUM_SEG7, 6, number of 7-segment digits (1..8)
- LED_W, 10, LED output width (1..16)
- SW_W, 10, switch input width (1..16)
- NUM_BTN, 2, number of push buttons (1..8)
- DEBOUNCE_CYC, 16, consecutive stable cycles required to accept a button level change (>=2)
- CR_BASE, 32'h0000_7000, CR window base; matched on AluOut[31:12]
- Clock  in  1  single clock; all state on rising edge
- Rst  in  1  reset, asynchronous and active-low
- AluOut  in  32  access address
- RegRdData2  in  32  store data
- CtrlCRMemWrEn  in  1  store strobe
- CtrlCRMemByteEn  in  4  store byte enables
- SelCRMemWb  in  1  load strobe
- CRMemRdDataQ104H  out  32  registered load data
- Button  in  NUM_BTN  raw asynchronous buttons
- Switch  in  SW_W  raw asynchronous switches
- SEG7  out  8*NUM_SEG7  digit i on bits [8i+7:8i]
- LED  out  LED_W  LED drive
- Irq  out  1  button-event interrupt

## Operation
- Hit: AluOut[31:12]==CR_BASE[31:12]; offset = AluOut[11:2]*4; AluOut[1:0] ignored.
- Map (word offsets): 0x00+4i SEG7_i (RW, byte 0, i<NUM_SEG7); 0x20 LED (RW, LED_W bits); 0x24 CURSOR_H (RW, 32); 0x28 CURSOR_V (RW, 32); 0x40 BTN_LVL (RO, debounced levels); 0x44 BTN_EVT (RW1C); 0x48 BTN_IE (RW, NUM_BTN bits); 0x4C SWITCH (RO, synchronised); 0x50 CYCLE (RO, 32-bit counter).
- Reads zero-extend; unmapped or miss reads return 0; writes to RO/unmapped/miss ignored.
- Writes honour CtrlCRMemByteEn per byte; bits above field width are dropped.
- Button and Switch each pass a 2-flop synchroniser before use.
- Debounce per button: counter clears when synced level equals debounced level; otherwise increments; when count reaches DEBOUNCE_CYC-1 and still differs, debounced level flips and counter clears.
- Rising edge of a debounced level sets BTN_EVT[b]. Writing 1 with byte 0 enabled clears it; a set in the same cycle wins over the clear.
- Irq = registered |(BTN_EVT & BTN_IE).
- CYCLE increments every clock and wraps 32'hFFFF_FFFF -> 0.
- Simultaneous load+store to same address: load returns the post-write value (write bypass). BTN_EVT load returns the value after set/clear resolution.

## Timing
- Reset (Rst=0, async): all registers, counters, synchronisers, CRMemRdDataQ104H, SEG7, LED, Irq = 0.
- Store at edge N: register, SEG7 and LED outputs reflect the new value after edge N.
- Load: SelCRMemWb+AluOut sampled at edge N; CRMemRdDataQ104H valid after edge N, held until the next load. With SelCRMemWb=0 the output holds its value.
- Switch: pin change sampled at edge N is readable in SWITCH from edge N+2.
- Button: pin held stable from edge N gives synced level at N+2. Debounced level and EVT flip at N+1+DEBOUNCE_CYC. Irq asserts one edge later if enabled.
- A glitch shorter than DEBOUNCE_CYC synced cycles never changes the debounced level.
- Rst asserted mid-debounce or mid-load discards all state; the first load after release returns reset values.

## Test plan
- Reset: deassert Rst, load every mapped offset -> all 0 (except CYCLE running); SEG7=0, LED=0, Irq=0.
- Store 32'hA5A5_00FF to 0x20 with ByteEn=4'b0001 (LED_W=10) -> LED=10'h0FF next cycle; load returns 32'h0000_00FF. Store to 0x44C of another base -> no change.
- Button[0] pulse of DEBOUNCE_CYC-1 cycles -> BTN_LVL and BTN_EVT stay 0. Hold high -> BTN_EVT[0]=1 at pin+DEBOUNCE_CYC+1; with BTN_IE=1, Irq=1 one cycle later.
- W1C: write 1 to BTN_EVT[0] -> bit clears, Irq drops next cycle. Clear coincident with a new rising edge -> bit stays 1.
- Same-cycle store 8'h3F to SEG7_2 and load 0x08 -> CRMemRdDataQ104H=32'h3F. Load 0x50 twice k cycles apart -> difference k. Force counter wrap -> 0.
- Assert Rst mid-debounce with counter at DEBOUNCE_CYC-2 -> after release, no event without a full DEBOUNCE_CYC stable period.
